// File: rtl/neopixel_rx.sv
// NeoPixel (WS2812) receive decoder: pulse-width bit recovery, keeps word 0, forwards words 1+.
// data_valid/frame_end/err are registered one cycle after detection; fwd_out lags rx_in_i by 3 clk.
module neopixel_rx #(
  parameter int unsigned THRESH    = 12,
  parameter int unsigned MAX_HIGH  = 40,
  parameter int unsigned RESET_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in_i,
  input  logic        bits32_i,
  output logic [31:0] data_out_o,
  output logic        data_valid_o,
  output logic [7:0]  pixel_index_o,
  output logic        frame_end_o,
  output logic        err_o,
  output logic        fwd_out_o
);

  localparam logic [5:0]  THRESH_C = 6'(THRESH);
  localparam logic [5:0]  MAXH_C   = 6'(MAX_HIGH);
  localparam logic [10:0] RESET_C  = 11'(RESET_CYC);

  typedef enum logic [1:0] {S_GAP, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t      state_q;
  logic        sync_q, rx_s_q, rx_d_q;
  logic [5:0]  hcnt_q;
  logic [10:0] lcnt_q;
  logic [5:0]  bit_cnt_q;
  logic [31:0] shift_q;
  logic [7:0]  widx_q;
  logic        mode32_q, fwd_en_q;
  logic [31:0] data_q;
  logic        data_valid_q, frame_end_q, err_q, fwd_out_q;
  logic [7:0]  pixel_index_q;

  logic        rise, fall, bit_val, word_done;
  logic [31:0] shift_d;
  logic [5:0]  bit_cnt_d;

  always_comb begin
    rise      = rx_s_q & ~rx_d_q;
    fall      = ~rx_s_q & rx_d_q;
    bit_val   = (hcnt_q >= THRESH_C);
    shift_d   = {shift_q[30:0], bit_val};
    bit_cnt_d = bit_cnt_q + 6'd1;
    word_done = (bit_cnt_d == (mode32_q ? 6'd32 : 6'd24));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_GAP;
      sync_q        <= 1'b0;
      rx_s_q        <= 1'b0;
      rx_d_q        <= 1'b0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      widx_q        <= '0;
      mode32_q      <= 1'b0;
      fwd_en_q      <= 1'b0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      pixel_index_q <= '0;
      frame_end_q   <= 1'b0;
      err_q         <= 1'b0;
      fwd_out_q     <= 1'b0;
    end else begin
      sync_q <= rx_in_i;
      rx_s_q <= sync_q;
      rx_d_q <= rx_s_q;
      // Both counters saturate so a stuck line never aliases into a valid width.
      hcnt_q <= rx_s_q ? ((hcnt_q == 6'd63) ? hcnt_q : hcnt_q + 6'd1) : 6'd0;
      lcnt_q <= rx_s_q ? 11'd0 : ((lcnt_q == 11'd2047) ? lcnt_q : lcnt_q + 11'd1);
      fwd_out_q    <= fwd_en_q & rx_s_q;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        S_GAP: begin
          if (lcnt_q >= RESET_C) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (rise) begin
            state_q   <= S_HIGH;
            bit_cnt_q <= '0;
            widx_q    <= '0;
            shift_q   <= '0;
            mode32_q  <= bits32_i;
          end
        end
        S_HIGH: begin
          if (hcnt_q > MAXH_C) begin
            err_q    <= 1'b1;
            fwd_en_q <= 1'b0;
            state_q  <= S_GAP;
          end else if (fall) begin
            shift_q <= shift_d;
            state_q <= S_LOW;
            if (word_done) begin
              data_q        <= mode32_q ? shift_d : {8'h00, shift_d[23:0]};
              data_valid_q  <= 1'b1;
              pixel_index_q <= widx_q;
              if (widx_q != 8'hFF) widx_q <= widx_q + 8'd1;
              bit_cnt_q     <= '0;
              fwd_en_q      <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end
        end
        S_LOW: begin
          if (lcnt_q >= RESET_C) begin
            frame_end_q <= 1'b1;
            err_q       <= (bit_cnt_q != 6'd0);
            fwd_en_q    <= 1'b0;
            state_q     <= S_IDLE;
          end else if (rise) begin
            state_q <= S_HIGH;
          end
        end
        default: state_q <= S_GAP;
      endcase
    end
  end

  assign data_out_o    = data_q;
  assign data_valid_o  = data_valid_q;
  assign pixel_index_o = pixel_index_q;
  assign frame_end_o   = frame_end_q;
  assign err_o         = err_q;
  assign fwd_out_o     = fwd_out_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// Bench for neopixel_rx: randomized pulse streams checked against word/index expectations
// derived from the transmitted bit sequence; forwarding checked against a 3-cycle delayed copy.
module tb_neopixel_rx;
  localparam int THRESH = 12, MAX_HIGH = 40, RESET_CYC = 1024;

  logic clk = 1'b0, rst = 1'b0, rx_in = 1'b0, bits32 = 1'b0;
  logic [31:0] data_out;
  logic        data_valid, frame_end, err, fwd_out;
  logic [7:0]  pixel_index;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  neopixel_rx #(.THRESH(THRESH), .MAX_HIGH(MAX_HIGH), .RESET_CYC(RESET_CYC)) dut (
    .clk(clk), .rst(rst), .rx_in_i(rx_in), .bits32_i(bits32),
    .data_out_o(data_out), .data_valid_o(data_valid), .pixel_index_o(pixel_index),
    .frame_end_o(frame_end), .err_o(err), .fwd_out_o(fwd_out));

  logic [31:0] dv_data_q[$];
  int          dv_idx_q[$];
  int          fe_cnt = 0, err_cnt = 0, fe_err_cnt = 0;
  logic        fwd_chk = 1'b0, fwd_flag = 1'b0;
  logic [2:0]  rx_h = '0, fl_h = '0;
  int          fwd_bad = 0, fwd_hi = 0, exp_fwd_hi = 0;
  logic [31:0] frame_q[$];

  always @(negedge clk) begin
    if (data_valid) begin
      dv_data_q.push_back(data_out);
      dv_idx_q.push_back(int'(pixel_index));
    end
    if (frame_end) fe_cnt++;
    if (err) err_cnt++;
    if (frame_end && err) fe_err_cnt++;
    if (fwd_chk) begin
      if (fwd_out !== (rx_h[2] & fl_h[2])) fwd_bad++;
      if (fwd_out) fwd_hi++;
    end
    rx_h = {rx_h[1:0], rx_in};
    fl_h = {fl_h[1:0], fwd_flag};
  end

  task automatic clear_mon();
    dv_data_q.delete();
    dv_idx_q.delete();
    fe_cnt = 0; err_cnt = 0; fe_err_cnt = 0;
    fwd_bad = 0; fwd_hi = 0; exp_fwd_hi = 0;
  endtask

  function automatic int rand_hi(input logic b);
    return b ? int'($urandom_range(MAX_HIGH, THRESH)) : int'($urandom_range(THRESH - 1, 1));
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] w, input int nb);
    return (nb == 24) ? {8'h00, w[23:0]} : w;
  endfunction

  // All drivers start and end at posedge+1.
  task automatic pulse(input int hi, input int lo);
    rx_in = 1'b1;
    if (fwd_flag) exp_fwd_hi += hi;
    repeat (hi) @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    rx_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int nb, input bit fast);
    for (int i = nb - 1; i >= 0; i--) begin
      if (fast) pulse(w[i] ? THRESH : 1, 1);
      else      pulse(rand_hi(w[i]), int'($urandom_range(20, 1)));
    end
  endtask

  task automatic send_frame(input int nb, input bit fast);
    for (int k = 0; k < frame_q.size(); k++) begin
      fwd_flag = (k > 0);
      send_word(frame_q[k], nb, fast);
    end
    fwd_flag = 1'b0;
    gap(1100);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", data_valid); end
    total++; if (pixel_index !== 8'h0) begin bad++; $display("FAIL reset_idx got=%0d want=0", pixel_index); end
    total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_end); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (fwd_out !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b want=0", fwd_out); end
    rst = 1'b1;
    gap(1100);
  endtask

  task automatic test_basic();
    logic [23:0] w;
    w = 24'h660000;
    clear_mon();
    for (int i = 23; i >= 0; i--) pulse(w[i] ? 16 : 8, w[i] ? 10 : 18);
    gap(1100);
    total++; if (dv_data_q.size() !== 1) begin bad++; $display("FAIL basic_dv_count got=%0d want=1", dv_data_q.size()); end
    else begin
      total++; if (dv_data_q[0] !== 32'h00660000) begin bad++; $display("FAIL basic_data got=%h want=00660000", dv_data_q[0]); end
      total++; if (dv_idx_q[0] !== 0) begin bad++; $display("FAIL basic_idx got=%0d want=0", dv_idx_q[0]); end
    end
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL basic_fe got=%0d want=1", fe_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL basic_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_three_words();
    frame_q = '{32'h333300, 32'h006600, 32'h003333};
    clear_mon();
    fwd_chk = 1'b1;
    send_frame(24, 1'b0);
    fwd_chk = 1'b0;
    total++; if (dv_data_q.size() !== 3) begin bad++; $display("FAIL three_dv_count got=%0d want=3", dv_data_q.size()); end
    for (int k = 0; k < 3 && k < dv_data_q.size(); k++) begin
      total++; if (dv_data_q[k] !== frame_q[k]) begin bad++; $display("FAIL three_data[%0d] got=%h want=%h", k, dv_data_q[k], frame_q[k]); end
      total++; if (dv_idx_q[k] !== k) begin bad++; $display("FAIL three_idx[%0d] got=%0d want=%0d", k, dv_idx_q[k], k); end
    end
    total++; if (fe_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL three_fe_err got fe=%0d err=%0d want fe=1 err=0", fe_cnt, err_cnt); end
    total++; if (fwd_bad !== 0) begin bad++; $display("FAIL three_fwd_cycles got=%0d bad cycles want=0", fwd_bad); end
    total++; if (fwd_hi !== exp_fwd_hi) begin bad++; $display("FAIL three_fwd_high got=%0d want=%0d", fwd_hi, exp_fwd_hi); end
  endtask

  task automatic test_thresh();
    logic [23:0] w;
    w = 24'($urandom) ^ 24'hA5A5A5;
    clear_mon();
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) pulse((i % 5 == 0) ? MAX_HIGH : THRESH, 7);
      else      pulse((i % 7 == 0) ? 1 : THRESH - 1, 7);
    end
    gap(1100);
    total++; if (dv_data_q.size() !== 1) begin bad++; $display("FAIL thresh_dv_count got=%0d want=1", dv_data_q.size()); end
    else begin
      total++; if (dv_data_q[0] !== {8'h00, w}) begin bad++; $display("FAIL thresh_data got=%h want=%h", dv_data_q[0], {8'h00, w}); end
    end
    total++; if (err_cnt !== 0 || fe_cnt !== 1) begin bad++; $display("FAIL thresh_fe_err got fe=%0d err=%0d want fe=1 err=0", fe_cnt, err_cnt); end
  endtask

  task automatic test_bits32();
    logic [31:0] w2;
    w2 = $urandom;
    clear_mon();
    bits32 = 1'b1;
    send_word(32'h12345678, 32, 1'b0);
    bits32 = 1'b0;
    send_word(w2, 32, 1'b0);
    gap(1100);
    total++; if (dv_data_q.size() !== 2) begin bad++; $display("FAIL b32_dv_count got=%0d want=2", dv_data_q.size()); end
    else begin
      total++; if (dv_data_q[0] !== 32'h12345678) begin bad++; $display("FAIL b32_data0 got=%h want=12345678", dv_data_q[0]); end
      total++; if (dv_data_q[1] !== w2) begin bad++; $display("FAIL b32_data1 got=%h want=%h", dv_data_q[1], w2); end
      total++; if (dv_idx_q[1] !== 1) begin bad++; $display("FAIL b32_idx1 got=%0d want=1", dv_idx_q[1]); end
    end
  endtask

  task automatic test_max_high();
    logic [31:0] w;
    w = $urandom;
    clear_mon();
    for (int i = 23; i >= 19; i--) pulse(rand_hi(w[i]), 5);
    pulse(MAX_HIGH + 1, 6);
    for (int i = 18; i >= 0; i--) pulse(rand_hi(w[i]), 5);
    gap(1100);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL maxh_err got=%0d want=1", err_cnt); end
    total++; if (dv_data_q.size() !== 0) begin bad++; $display("FAIL maxh_dv got=%0d want=0", dv_data_q.size()); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL maxh_fe got=%0d want=0", fe_cnt); end
    frame_q = '{w};
    clear_mon();
    send_frame(24, 1'b0);
    total++; if (dv_data_q.size() !== 1) begin bad++; $display("FAIL maxh_next_dv got=%0d want=1", dv_data_q.size()); end
    else begin
      total++; if (dv_data_q[0] !== exp_word(w, 24) || dv_idx_q[0] !== 0) begin bad++; $display("FAIL maxh_next_word got=%h/%0d want=%h/0", dv_data_q[0], dv_idx_q[0], exp_word(w, 24)); end
    end
    total++; if (fe_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL maxh_next_fe_err got fe=%0d err=%0d want 1/0", fe_cnt, err_cnt); end
  endtask

  task automatic test_partial();
    logic [31:0] w;
    w = $urandom;
    clear_mon();
    for (int i = 9; i >= 0; i--) pulse(rand_hi(w[i]), 4);
    gap(1100);
    total++; if (fe_err_cnt !== 1) begin bad++; $display("FAIL part_same_cycle got=%0d want=1", fe_err_cnt); end
    total++; if (fe_cnt !== 1 || err_cnt !== 1) begin bad++; $display("FAIL part_counts got fe=%0d err=%0d want 1/1", fe_cnt, err_cnt); end
    total++; if (dv_data_q.size() !== 0) begin bad++; $display("FAIL part_dv got=%0d want=0", dv_data_q.size()); end
    frame_q = '{w ^ 32'h00FF00FF};
    clear_mon();
    send_frame(24, 1'b0);
    total++; if (dv_data_q.size() !== 1) begin bad++; $display("FAIL part_next_dv got=%0d want=1", dv_data_q.size()); end
    else begin
      total++; if (dv_data_q[0] !== exp_word(frame_q[0], 24)) begin bad++; $display("FAIL part_next_data got=%h want=%h", dv_data_q[0], exp_word(frame_q[0], 24)); end
    end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL part_next_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0, w1, w2;
    w0 = $urandom | 32'h1; w1 = $urandom; w2 = $urandom;
    clear_mon();
    send_word(w0, 24, 1'b0);
    for (int i = 23; i >= 14; i--) pulse(rand_hi(w1[i]), 5);
    total++; if (dv_data_q.size() !== 1) begin bad++; $display("FAIL rmid_word0 got=%0d dv want=1", dv_data_q.size()); end
    rx_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (data_out !== 32'h0 || pixel_index !== 8'h0) begin bad++; $display("FAIL rmid_data_idx got=%h/%0d want=0/0", data_out, pixel_index); end
    total++; if ({data_valid, frame_end, err, fwd_out} !== 4'b0) begin bad++; $display("FAIL rmid_pulses got=%b want=0000", {data_valid, frame_end, err, fwd_out}); end
    repeat (2) @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 12; i >= 9; i--) pulse(rand_hi(w1[i]), 5);
    rst = 1'b1;
    clear_mon();
    for (int i = 8; i >= 0; i--) pulse(rand_hi(w1[i]), 5);
    send_word(w2, 24, 1'b0);
    gap(1100);
    total++; if (dv_data_q.size() !== 0) begin bad++; $display("FAIL rmid_ignored_dv got=%0d want=0", dv_data_q.size()); end
    total++; if (fe_cnt !== 0 || err_cnt !== 0) begin bad++; $display("FAIL rmid_ignored_fe_err got fe=%0d err=%0d want 0/0", fe_cnt, err_cnt); end
    frame_q = '{w2};
    clear_mon();
    send_frame(24, 1'b0);
    total++; if (dv_data_q.size() !== 1) begin bad++; $display("FAIL rmid_next_dv got=%0d want=1", dv_data_q.size()); end
    else begin
      total++; if (dv_data_q[0] !== exp_word(w2, 24) || dv_idx_q[0] !== 0) begin bad++; $display("FAIL rmid_next_word got=%h/%0d want=%h/0", dv_data_q[0], dv_idx_q[0], exp_word(w2, 24)); end
    end
  endtask

  task automatic test_random();
    int nw, nb;
    for (int f = 0; f < 3; f++) begin
      nw = int'($urandom_range(4, 1));
      nb = ($urandom % 2 == 0) ? 24 : 32;
      bits32 = (nb == 32);
      frame_q.delete();
      for (int k = 0; k < nw; k++) frame_q.push_back($urandom);
      clear_mon();
      fwd_chk = 1'b1;
      send_frame(nb, 1'b0);
      fwd_chk = 1'b0;
      bits32 = 1'b0;
      total++; if (dv_data_q.size() !== nw) begin bad++; $display("FAIL rand%0d_dv_count got=%0d want=%0d", f, dv_data_q.size(), nw); end
      for (int k = 0; k < nw && k < dv_data_q.size(); k++) begin
        total++; if (dv_data_q[k] !== exp_word(frame_q[k], nb) || dv_idx_q[k] !== k) begin
          bad++; $display("FAIL rand%0d_word[%0d] got=%h/%0d want=%h/%0d", f, k, dv_data_q[k], dv_idx_q[k], exp_word(frame_q[k], nb), k);
        end
      end
      total++; if (fe_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL rand%0d_fe_err got fe=%0d err=%0d want 1/0", f, fe_cnt, err_cnt); end
      total++; if (fwd_bad !== 0 || fwd_hi !== exp_fwd_hi) begin bad++; $display("FAIL rand%0d_fwd got bad=%0d hi=%0d want bad=0 hi=%0d", f, fwd_bad, fwd_hi, exp_fwd_hi); end
    end
  endtask

  task automatic test_saturate();
    int n;
    n = 258;
    frame_q.delete();
    for (int k = 0; k < n; k++) frame_q.push_back((k >= 252) ? $urandom : 32'h0);
    clear_mon();
    fwd_chk = 1'b1;
    send_frame(24, 1'b1);
    fwd_chk = 1'b0;
    total++; if (dv_data_q.size() !== n) begin bad++; $display("FAIL sat_dv_count got=%0d want=%0d", dv_data_q.size(), n); end
    for (int k = 0; k < n && k < dv_data_q.size(); k++) begin
      total++; if (dv_idx_q[k] !== ((k > 255) ? 255 : k)) begin bad++; $display("FAIL sat_idx[%0d] got=%0d want=%0d", k, dv_idx_q[k], (k > 255) ? 255 : k); end
      total++; if (dv_data_q[k] !== exp_word(frame_q[k], 24)) begin bad++; $display("FAIL sat_data[%0d] got=%h want=%h", k, dv_data_q[k], exp_word(frame_q[k], 24)); end
    end
    total++; if (fwd_bad !== 0 || fwd_hi !== exp_fwd_hi) begin bad++; $display("FAIL sat_fwd got bad=%0d hi=%0d want bad=0 hi=%0d", fwd_bad, fwd_hi, exp_fwd_hi); end
    total++; if (fe_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL sat_fe_err got fe=%0d err=%0d want 1/0", fe_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_three_words();
    test_thresh();
    test_bits32();
    test_max_high();
    test_partial();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
